wb_write_queue: RTL and testbench

WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/wb_write_queue_if.sv | 49 ++++
 rtl/wbq_match.sv | 34 +++
 rtl/wb_write_queue.sv | 121 ++++++++++++
 tb/tb_wb_write_queue.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index and write-queue entry.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // One pending register-file write: destination register and its data.
    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wbq_entry_t;

    localparam regbits_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_write_queue_if.sv
// Bus bundle for the writeback queue: two source handshakes, register-file
// write port, decode-stage forwarding lookups and occupancy status.
interface wb_write_queue_if;
    import cpu_types_pkg::*;

    logic       mem_valid;
    logic       mem_ready;
    regbits_t   mem_wsel;
    word_t      mem_wdat;
    logic       alu_valid;
    logic       alu_ready;
    regbits_t   alu_wsel;
    word_t      alu_wdat;
    logic       rf_WEN;
    regbits_t   rf_wsel;
    word_t      rf_wdat;
    regbits_t   rsel1;
    regbits_t   rsel2;
    logic       hit1;
    logic       hit2;
    word_t      fwd1;
    word_t      fwd2;
    logic [3:0] count;
    logic       full;
    logic       empty;

    // Producer / consumer side (pipeline stages and register file).
    modport master (
        output mem_valid, mem_wsel, mem_wdat,
        output alu_valid, alu_wsel, alu_wdat,
        output rsel1, rsel2,
        input  mem_ready, alu_ready,
        input  rf_WEN, rf_wsel, rf_wdat,
        input  hit1, hit2, fwd1, fwd2,
        input  count, full, empty
    );

    // Queue side.
    modport slave (
        input  mem_valid, mem_wsel, mem_wdat,
        input  alu_valid, alu_wsel, alu_wdat,
        input  rsel1, rsel2,
        output mem_ready, alu_ready,
        output rf_WEN, rf_wsel, rf_wdat,
        output hit1, hit2, fwd1, fwd2,
        output count, full, empty
    );

endinterface

// File: rtl/wbq_match.sv
// Youngest-match search over queued writes for one decode read port.
module wbq_match
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wbq_entry_t [DEPTH-1:0] entries_i,
    input  logic [DEPTH-1:0]       valid_i,
    input  logic [PTR_W-1:0]       head_i,
    input  regbits_t               rsel_i,
    output logic                   hit_o,
    output word_t                  fwd_o
);

    // Walk entries oldest to youngest from the head so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit_o = 1'b0;
        fwd_o = 32'h0000_0000;
        idx   = head_i;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if (valid_i[idx] && (entries_i[idx].wsel == rsel_i) && (rsel_i != REG_ZERO)) begin
                hit_o = 1'b1;
                fwd_o = entries_i[idx].wdat;
            end else begin
                hit_o = hit_o;
                fwd_o = fwd_o;
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback queue: merges load and ALU results into one register-file write
// port, draining one entry per cycle and forwarding pending data to decode.
module wb_write_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic             CLK,
    input logic             RST,
    wb_write_queue_if.slave bus
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    wbq_entry_t [DEPTH-1:0] ent_q, ent_d;
    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [3:0]             count_q, count_d;

    logic [3:0] free_s;
    logic       mem_ready_s, alu_ready_s;
    logic       mem_wr_s, alu_wr_s, pop_s;

    // Free slots come from start-of-cycle occupancy; a same-cycle pop is not credited.
    assign free_s      = DEPTH_C - count_q;
    assign mem_ready_s = !RST && (free_s >= 4'd1);
    assign alu_ready_s = !RST && ((free_s >= 4'd2) || ((free_s >= 4'd1) && !bus.mem_valid));

    // Writes to r0 complete the handshake but never occupy a slot.
    assign mem_wr_s = bus.mem_valid && mem_ready_s && (bus.mem_wsel != REG_ZERO);
    assign alu_wr_s = bus.alu_valid && alu_ready_s && (bus.alu_wsel != REG_ZERO);
    assign pop_s    = (count_q != 4'd0);

    // Next state: pop the head, then append mem ahead of alu at the tail.
    always_comb begin
        logic [PTR_W-1:0] wptr;
        ent_d   = ent_q;
        vld_d   = vld_q;
        head_d  = head_q;
        wptr    = tail_q;
        if (pop_s) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end
        if (mem_wr_s) begin
            ent_d[wptr] = '{wsel: bus.mem_wsel, wdat: bus.mem_wdat};
            vld_d[wptr] = 1'b1;
            wptr        = wptr + PTR_W'(1);
        end else begin
            wptr = wptr;
        end
        if (alu_wr_s) begin
            ent_d[wptr] = '{wsel: bus.alu_wsel, wdat: bus.alu_wdat};
            vld_d[wptr] = 1'b1;
            wptr        = wptr + PTR_W'(1);
        end else begin
            wptr = wptr;
        end
        tail_d  = wptr;
        count_d = count_q + {3'b000, mem_wr_s} + {3'b000, alu_wr_s} - {3'b000, pop_s};
    end

    // State registers; reset wins over any same-cycle push or pop.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ent_q   <= '0;
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 4'd0;
        end else begin
            ent_q   <= ent_d;
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Register-file port shows the head entry whenever the queue is non-empty.
    always_comb begin
        if (count_q != 4'd0) begin
            bus.rf_WEN  = 1'b1;
            bus.rf_wsel = ent_q[head_q].wsel;
            bus.rf_wdat = ent_q[head_q].wdat;
        end else begin
            bus.rf_WEN  = 1'b0;
            bus.rf_wsel = 5'd0;
            bus.rf_wdat = 32'h0000_0000;
        end
    end

    assign bus.mem_ready = mem_ready_s;
    assign bus.alu_ready = alu_ready_s;
    assign bus.count     = count_q;
    assign bus.full      = (count_q == DEPTH_C);
    assign bus.empty     = (count_q == 4'd0);

    wbq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match1 (
        .entries_i (ent_q),
        .valid_i   (vld_q),
        .head_i    (head_q),
        .rsel_i    (bus.rsel1),
        .hit_o     (bus.hit1),
        .fwd_o     (bus.fwd1)
    );

    wbq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match2 (
        .entries_i (ent_q),
        .valid_i   (vld_q),
        .head_i    (head_q),
        .rsel_i    (bus.rsel2),
        .hit_o     (bus.hit2),
        .fwd_o     (bus.fwd2)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Self-checking bench for wb_write_queue: directed vector table, a streaming
// sequence, and randomized traffic checked against a queue-based model.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    wb_write_queue_if bus ();

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0]  wsel;
        logic [31:0] wdat;
    } ment_t;

    ment_t mq[$];

    // Inputs of the current cycle and model-side readies, kept for the update step.
    logic        c_rst, c_mv, c_av;
    logic [4:0]  c_mws, c_aws;
    logic [31:0] c_mwd, c_awd;
    logic        m_mr, m_ar;

    typedef struct {
        logic rst; logic mv; logic [4:0] mws; logic [31:0] mwd;
        logic av;  logic [4:0] aws; logic [31:0] awd;
        logic [4:0] r1; logic [4:0] r2;
        logic e_mr; logic e_ar; logic e_wen; logic [4:0] e_wsel; logic [31:0] e_wdat;
        logic e_hit1; logic [31:0] e_fwd1; logic [3:0] e_cnt;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Youngest queued write to rsel, ignoring r0.
    task automatic lookup(input logic [4:0] rsel, output logic hit, output logic [31:0] fwd);
        hit = 1'b0;
        fwd = 32'h0;
        foreach (mq[i]) begin
            if (rsel != 5'd0 && mq[i].wsel == rsel) begin
                hit = 1'b1;
                fwd = mq[i].wdat;
            end
        end
    endtask

    // Drive one cycle of inputs and compare every output against the model.
    task automatic apply(input logic rst, input logic mv, input logic [4:0] mws, input logic [31:0] mwd,
                         input logic av, input logic [4:0] aws, input logic [31:0] awd,
                         input logic [4:0] r1, input logic [4:0] r2);
        int          free;
        logic        h1, h2;
        logic [31:0] f1, f2;
        @(negedge CLK);
        RST = rst;
        bus.mem_valid = mv; bus.mem_wsel = mws; bus.mem_wdat = mwd;
        bus.alu_valid = av; bus.alu_wsel = aws; bus.alu_wdat = awd;
        bus.rsel1 = r1; bus.rsel2 = r2;
        c_rst = rst; c_mv = mv; c_mws = mws; c_mwd = mwd; c_av = av; c_aws = aws; c_awd = awd;
        #1;
        free = DEPTH - mq.size();
        m_mr = !rst && (free >= 1);
        m_ar = !rst && ((free >= 2) || (free >= 1 && !mv));
        chk("mem_ready", {31'd0, bus.mem_ready}, {31'd0, m_mr});
        chk("alu_ready", {31'd0, bus.alu_ready}, {31'd0, m_ar});
        chk("rf_WEN", {31'd0, bus.rf_WEN}, {31'd0, (mq.size() > 0)});
        chk("rf_wsel", {27'd0, bus.rf_wsel}, (mq.size() > 0) ? {27'd0, mq[0].wsel} : 32'd0);
        chk("rf_wdat", bus.rf_wdat, (mq.size() > 0) ? mq[0].wdat : 32'd0);
        lookup(r1, h1, f1);
        lookup(r2, h2, f2);
        chk("hit1", {31'd0, bus.hit1}, {31'd0, h1});
        chk("fwd1", bus.fwd1, f1);
        chk("hit2", {31'd0, bus.hit2}, {31'd0, h2});
        chk("fwd2", bus.fwd2, f2);
        chk("count", {28'd0, bus.count}, 32'(mq.size()));
        chk("full", {31'd0, bus.full}, {31'd0, (mq.size() == DEPTH)});
        chk("empty", {31'd0, bus.empty}, {31'd0, (mq.size() == 0)});
    endtask

    // Advance the model by one clock and take the edge.
    task automatic step();
        if (c_rst) begin
            mq.delete();
        end else begin
            if (mq.size() > 0) void'(mq.pop_front());
            if (c_mv && m_mr && c_mws != 5'd0) mq.push_back('{wsel: c_mws, wdat: c_mwd});
            if (c_av && m_ar && c_aws != 5'd0) mq.push_back('{wsel: c_aws, wdat: c_awd});
        end
        @(posedge CLK);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b1;
        bus.mem_valid = 1'b0; bus.mem_wsel = 5'd0; bus.mem_wdat = 32'd0;
        bus.alu_valid = 1'b0; bus.alu_wsel = 5'd0; bus.alu_wdat = 32'd0;
        bus.rsel1 = 5'd0; bus.rsel2 = 5'd0;
        repeat (2) @(posedge CLK);
        mq.delete();

        //           rst   mv    mws    mwd           av    aws    awd           r1     r2     mr    ar    wen   wsel   wdat          hit1  fwd1          cnt
        tbl[0]  = '{1'b1, 1'b1, 5'd5, 32'h0,         1'b1, 5'd6, 32'h0,        5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[1]  = '{1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 4'd1};
        tbl[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[4]  = '{1'b0, 1'b1, 5'd3, 32'h1,         1'b1, 5'd3, 32'h2,        5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1,         1'b1, 32'h2,         4'd2};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h2,         1'b1, 32'h2,         4'd1};
        tbl[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'h1234,     5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[8]  = '{1'b0, 1'b1, 5'd1, 32'h11,        1'b1, 5'd2, 32'h22,       5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         4'd0};
        tbl[9]  = '{1'b0, 1'b1, 5'd3, 32'h33,        1'b1, 5'd4, 32'h44,       5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h11,        1'b0, 32'h0,         4'd2};
        tbl[10] = '{1'b0, 1'b1, 5'd5, 32'h55,        1'b1, 5'd6, 32'h66,       5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h22,        1'b1, 32'h22,        4'd3};
        tbl[11] = '{1'b1, 1'b1, 5'd7, 32'h77,        1'b0, 5'd0, 32'h0,        5'd4, 5'd5, 1'b0, 1'b0, 1'b1, 5'd3, 32'h33,        1'b1, 32'h44,        4'd3};
        tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,         1'b0, 32'h0,         4'd0};

        // Directed table: each row's expectations hold before that row's clock edge.
        for (int v = 0; v < 13; v++) begin
            apply(tbl[v].rst, tbl[v].mv, tbl[v].mws, tbl[v].mwd, tbl[v].av, tbl[v].aws, tbl[v].awd,
                  tbl[v].r1, tbl[v].r2);
            chk($sformatf("tbl%0d_mem_ready", v), {31'd0, bus.mem_ready}, {31'd0, tbl[v].e_mr});
            chk($sformatf("tbl%0d_alu_ready", v), {31'd0, bus.alu_ready}, {31'd0, tbl[v].e_ar});
            chk($sformatf("tbl%0d_rf_WEN", v), {31'd0, bus.rf_WEN}, {31'd0, tbl[v].e_wen});
            chk($sformatf("tbl%0d_rf_wsel", v), {27'd0, bus.rf_wsel}, {27'd0, tbl[v].e_wsel});
            chk($sformatf("tbl%0d_rf_wdat", v), bus.rf_wdat, tbl[v].e_wdat);
            chk($sformatf("tbl%0d_hit1", v), {31'd0, bus.hit1}, {31'd0, tbl[v].e_hit1});
            chk($sformatf("tbl%0d_fwd1", v), bus.fwd1, tbl[v].e_fwd1);
            chk($sformatf("tbl%0d_count", v), {28'd0, bus.count}, {28'd0, tbl[v].e_cnt});
            step();
        end

        // Sustained one-per-cycle ALU stream r1..r8 through the wrapping pointers.
        for (int i = 1; i <= 10; i++) begin
            apply(1'b0, 1'b0, 5'd0, 32'd0, (i <= 8) ? 1'b1 : 1'b0, 5'(i), 32'(i * 256),
                  5'd0, 5'd0);
            chk("stream_count_le1", {31'd0, (bus.count <= 4'd1)}, 32'd1);
            if (i >= 2 && i <= 9) begin
                chk("stream_wen", {31'd0, bus.rf_WEN}, 32'd1);
                chk("stream_wsel", {27'd0, bus.rf_wsel}, 32'(i - 1));
                chk("stream_wdat", bus.rf_wdat, 32'((i - 1) * 256));
            end else if (i == 10) begin
                chk("stream_drained", {31'd0, bus.empty}, 32'd1);
            end
            step();
        end

        // Randomized traffic with narrow register range to provoke hits and r0 drops.
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
